pong_match_controller: RTL and testbench
========================================

# pong_match_controller

Match sequencer for the Pong datapath. It watches the ball's `missed`/`collided` events once per frame and keeps both players' scores. It drives the ball's `restart` input through the serve, play, point-pause and game-over phases. It sits in `pong_game` between `graphics` (`endofframe` source) and `ball_movement` (event source, `restart` sink), clocked by the 50 MHz system clock.

## Interface
Parameters:
- `WIN_SCORE`, default 11: points needed to win; legal range 1..15.
- `SERVE_FRAMES`, default 60: frames the ball is held at centre before play.
- `POINT_FRAMES`, default 30: pause frames after a point.
- `HITS_PER_LEVEL`, default 4: paddle hits per speed step. Used only with `RALLY_SPEEDUP_EN`.

Ports:
- `clk50M`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `endofframe`, in, 1: level from `graphics`; rises when the scan leaves the display area.
- `start`, in, 1: debounced start button, active-high.
- `collided`, in, 1: ball hit a paddle.
- `missed_one`, in, 1: player one failed to return the ball; point goes to player two.
- `missed_two`, in, 1: player two failed to return the ball; point goes to player one.
- `restart`, out, 1: holds the ball at centre.
- `play_en`, out, 1: high only in PLAY.
- `serve_dir`, out, 1: 0 = serve toward player one, 1 = serve toward player two.
- `score_one`, out, 4: player one's score.
- `score_two`, out, 4: player two's score.
- `game_over`, out, 1: high only in OVER.
- `winner`, out, 1: 0 = player one, 1 = player two; valid while `game_over` is high.
- `speed_level`, out, 2: ball speed step 0..3.

## Operation
Frame tick:
- `endofframe` passes through a 2-flop synchronizer into `clk50M`, then a rising-edge detect.
- The result is `ftick`, one cycle wide.
- All inputs are sampled and all state advances only on cycles where `ftick` is high.

Start edge:
- `start` is registered on each `ftick`.
- `start_rise` means `start` is 1 on this tick and was 0 on the previous tick.

States:
- IDLE: `restart`=1, `play_en`=0. On `start_rise`: go to SERVE and load the counter with SERVE_FRAMES-1.
- SERVE: `restart`=1. On each tick: if the counter is 0, go to PLAY; otherwise decrement the counter.
- PLAY: `restart`=0, `play_en`=1. A miss handled on a tick:
  - Increment the winning player's score.
  - Set `serve_dir` toward the player who lost the point.
  - If the new score equals WIN_SCORE: go to OVER and set `winner`.
  - Otherwise: go to POINT and load the counter with POINT_FRAMES-1.
- POINT: `restart`=0, `play_en`=0. Counts down like SERVE; at 0 go to SERVE and load SERVE_FRAMES-1.
- OVER: `restart`=1, `game_over`=1. On `start_rise`: clear both scores, go to SERVE and load SERVE_FRAMES-1.

Boundary rules:
- `missed_one` and `missed_two` on the same tick: no score change, `serve_dir` unchanged, go to POINT.
- A miss and `collided` on the same tick: the miss wins.
- Events outside PLAY are ignored.
- `start` held high through OVER does not restart the game; a release followed by a new press is required.
- Scores never exceed WIN_SCORE, so they need no saturation logic.

## Timing
- Reset values: state IDLE, counter 0, both scores 0, `serve_dir`=0, `winner`=0, `restart`=1, `play_en`=0, `game_over`=0, `speed_level`=0.
- Reset acts immediately and asynchronously, including mid-SERVE or mid-PLAY.
- `ftick` is high on the 3rd `clk50M` edge after `endofframe` rises.
- All outputs are registered. They change on the cycle after `ftick`, which is about 4 cycles after `endofframe` rises and a full frame before `ball_movement` samples them.
- SERVE lasts exactly SERVE_FRAMES ticks; POINT lasts exactly POINT_FRAMES ticks.
- `restart` stays high through all of SERVE, so the ball sees it on at least one of its frame edges.

## Configuration
- Macro: `PONG_RALLY_SPEEDUP_EN`.
- Defined:
  - A rally counter counts `collided` rising edges sampled on ticks in PLAY.
  - Every HITS_PER_LEVEL hits, `speed_level` increments, saturating at 3.
  - The rally counter and `speed_level` clear on entry to SERVE.
- Undefined: the counter is not built, and `speed_level` is the constant 0. The port still exists.

## Structure
- Shared package `pong_pkg`:
  - state encoding (IDLE, SERVE, PLAY, POINT, OVER)
  - player encoding (ONE=0, TWO=1)
  - default values of WIN_SCORE, SERVE_FRAMES and POINT_FRAMES
- Sub-module `pong_frame_tick`: synchronizer plus edge detector producing `ftick`. Reusable by the paddle logic.
- Counter width is $clog2 of the larger of SERVE_FRAMES and POINT_FRAMES.

## Test plan
- Reset mid-play: reach PLAY with score 3-2, then assert `reset` → same cycle: scores 0-0, `restart`=1, `play_en`=0, `game_over`=0.
- Serve timing: pulse `start` in IDLE → SERVE; `play_en` rises one cycle after the 60th following `ftick`.
- Single miss: `missed_one` on a tick at 0-0 → `score_two`=1, `serve_dir`=0, POINT; SERVE after 30 ticks.
- Win and re-arm: at 10-0, `missed_two` → `score_one`=11, `game_over`=1, `winner`=0. Holding `start` high does nothing; release then press → scores 0-0, SERVE.
- Double miss: `missed_one` and `missed_two` on the same tick → scores unchanged, POINT.
- `PONG_RALLY_SPEEDUP_EN` defined:
  - 8 `collided` pulses → `speed_level`=2
  - 13 pulses → 3 (saturated)
  - entry to SERVE → 0
  - with the macro undefined, `speed_level` stays 0 throughout.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and defaults for the Pong match logic.
// Optional rally speed-up is enabled with the PONG_RALLY_SPEEDUP_EN macro (see pong_match_controller).
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } match_state_t;

    typedef enum logic {
        PLAYER_ONE = 1'b0,
        PLAYER_TWO = 1'b1
    } player_t;

    localparam int DEF_WIN_SCORE      = 11;
    localparam int DEF_SERVE_FRAMES   = 60;
    localparam int DEF_POINT_FRAMES   = 30;
    localparam int DEF_HITS_PER_LEVEL = 4;

    // Bits needed to hold 0..max(a,b)-1, never less than one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pong_frame_tick.sv
// Brings the graphics end-of-frame level into the system clock domain and
// turns its rising edge into a single-cycle registered frame tick.
module pong_frame_tick (
    input  logic clk50M,
    input  logic reset,
    input  logic level,
    output logic ftick
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;
    logic tick_r;

    // Two-flop synchronizer followed by a registered rising-edge detect.
    always_ff @(posedge clk50M or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
            tick_r  <= 1'b0;
        end else begin
            sync1_r <= level;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            tick_r  <= sync2_r & ~prev_r;
        end
    end

    assign ftick = tick_r;

endmodule

// File: rtl/pong_match_controller.sv
// Frame-paced match sequencer: serve, play, point pause and game over, plus scoring.
// Define PONG_RALLY_SPEEDUP_EN to build the rally counter that drives speed_level.
module pong_match_controller
    import pong_pkg::*;
#(
    parameter int WIN_SCORE      = DEF_WIN_SCORE,
    parameter int SERVE_FRAMES   = DEF_SERVE_FRAMES,
    parameter int POINT_FRAMES   = DEF_POINT_FRAMES,
    parameter int HITS_PER_LEVEL = DEF_HITS_PER_LEVEL
) (
    input  logic       clk50M,
    input  logic       reset,
    input  logic       endofframe,
    input  logic       start,
    input  logic       collided,
    input  logic       missed_one,
    input  logic       missed_two,
    output logic       restart,
    output logic       play_en,
    output logic       serve_dir,
    output logic [3:0] score_one,
    output logic [3:0] score_two,
    output logic       game_over,
    output logic       winner,
    output logic [1:0] speed_level
);

    localparam int              CNT_W      = cnt_width(SERVE_FRAMES, POINT_FRAMES);
    localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0] POINT_LOAD = CNT_W'(POINT_FRAMES - 1);
    localparam logic [3:0]       WIN_VAL    = 4'(WIN_SCORE);

    logic             ftick_s;
    logic             start_rise_s;
    logic             serve_entry_s;
    logic             cnt_zero_s;
    logic [3:0]       score_one_inc_s;
    logic [3:0]       score_two_inc_s;

    match_state_t     state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             start_prev_r;
    logic [3:0]       score_one_r;
    logic [3:0]       score_two_r;
    logic             serve_dir_r;
    logic             winner_r;
    logic             restart_r;
    logic             play_en_r;
    logic             game_over_r;

    pong_frame_tick u_frame_tick (
        .clk50M (clk50M),
        .reset  (reset),
        .level  (endofframe),
        .ftick  (ftick_s)
    );

    // Tick-qualified start edge, counter-expiry flag and incremented scores.
    always_comb begin
        start_rise_s    = ftick_s & start & ~start_prev_r;
        cnt_zero_s      = (cnt_r == {CNT_W{1'b0}});
        score_one_inc_s = score_one_r + 4'd1;
        score_two_inc_s = score_two_r + 4'd1;
    end

    // Flags the tick on which the match enters SERVE from any state.
    always_comb begin
        serve_entry_s = 1'b0;
        if (ftick_s) begin
            case (state_r)
                ST_IDLE, ST_OVER: serve_entry_s = start_rise_s;
                ST_POINT:         serve_entry_s = cnt_zero_s;
                default:          serve_entry_s = 1'b0;
            endcase
        end else begin
            serve_entry_s = 1'b0;
        end
    end

    // Match state machine; outputs are set together with each transition.
    always_ff @(posedge clk50M or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            start_prev_r <= 1'b0;
            score_one_r  <= 4'd0;
            score_two_r  <= 4'd0;
            serve_dir_r  <= PLAYER_ONE;
            winner_r     <= PLAYER_ONE;
            restart_r    <= 1'b1;
            play_en_r    <= 1'b0;
            game_over_r  <= 1'b0;
        end else if (ftick_s) begin
            start_prev_r <= start;
            case (state_r)
                ST_IDLE, ST_OVER: begin
                    if (serve_entry_s) begin
                        state_r     <= ST_SERVE;
                        cnt_r       <= SERVE_LOAD;
                        score_one_r <= 4'd0;
                        score_two_r <= 4'd0;
                        restart_r   <= 1'b1;
                        play_en_r   <= 1'b0;
                        game_over_r <= 1'b0;
                    end
                end
                ST_SERVE: begin
                    if (cnt_zero_s) begin
                        state_r   <= ST_PLAY;
                        restart_r <= 1'b0;
                        play_en_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_PLAY: begin
                    // A simultaneous double miss is a replayed point with no score.
                    if (missed_one && missed_two) begin
                        state_r   <= ST_POINT;
                        cnt_r     <= POINT_LOAD;
                        play_en_r <= 1'b0;
                    end else if (missed_one) begin
                        score_two_r <= score_two_inc_s;
                        serve_dir_r <= PLAYER_ONE;
                        play_en_r   <= 1'b0;
                        if (score_two_inc_s == WIN_VAL) begin
                            state_r     <= ST_OVER;
                            winner_r    <= PLAYER_TWO;
                            restart_r   <= 1'b1;
                            game_over_r <= 1'b1;
                        end else begin
                            state_r <= ST_POINT;
                            cnt_r   <= POINT_LOAD;
                        end
                    end else if (missed_two) begin
                        score_one_r <= score_one_inc_s;
                        serve_dir_r <= PLAYER_TWO;
                        play_en_r   <= 1'b0;
                        if (score_one_inc_s == WIN_VAL) begin
                            state_r     <= ST_OVER;
                            winner_r    <= PLAYER_ONE;
                            restart_r   <= 1'b1;
                            game_over_r <= 1'b1;
                        end else begin
                            state_r <= ST_POINT;
                            cnt_r   <= POINT_LOAD;
                        end
                    end
                end
                ST_POINT: begin
                    if (serve_entry_s) begin
                        state_r   <= ST_SERVE;
                        cnt_r     <= SERVE_LOAD;
                        restart_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cnt_r       <= {CNT_W{1'b0}};
                    restart_r   <= 1'b1;
                    play_en_r   <= 1'b0;
                    game_over_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef PONG_RALLY_SPEEDUP_EN
    localparam int               HIT_W    = cnt_width(HITS_PER_LEVEL, 1);
    localparam logic [HIT_W-1:0] HIT_LAST = HIT_W'(HITS_PER_LEVEL - 1);

    logic             hit_s;
    logic             collided_prev_r;
    logic [HIT_W-1:0] hits_r;
    logic [1:0]       speed_r;

    // A counted hit is a new paddle contact during play that is not overridden by a miss.
    always_comb begin
        hit_s = ftick_s & (state_r == ST_PLAY) & collided & ~collided_prev_r
              & ~missed_one & ~missed_two;
    end

    // Rally counter: one speed step every HITS_PER_LEVEL hits, cleared at each serve.
    always_ff @(posedge clk50M or posedge reset) begin
        if (reset) begin
            collided_prev_r <= 1'b0;
            hits_r          <= {HIT_W{1'b0}};
            speed_r         <= 2'd0;
        end else if (ftick_s) begin
            collided_prev_r <= collided;
            if (serve_entry_s) begin
                hits_r  <= {HIT_W{1'b0}};
                speed_r <= 2'd0;
            end else if (hit_s) begin
                if (hits_r == HIT_LAST) begin
                    hits_r <= {HIT_W{1'b0}};
                    if (speed_r != 2'd3) begin
                        speed_r <= speed_r + 2'd1;
                    end
                end else begin
                    hits_r <= hits_r + {{(HIT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign speed_level = speed_r;
`else
    assign speed_level = 2'd0;
`endif

    assign restart   = restart_r;
    assign play_en   = play_en_r;
    assign serve_dir = serve_dir_r;
    assign score_one = score_one_r;
    assign score_two = score_two_r;
    assign game_over = game_over_r;
    assign winner    = winner_r;

endmodule

// File: tb/tb_pong_match_controller.sv
// Table-driven bench for pong_match_controller with a queue scoreboard;
// speed_level expectations follow the PONG_RALLY_SPEEDUP_EN macro.
module tb_pong_match_controller;

    logic       clk50M = 1'b0;
    logic       reset;
    logic       endofframe;
    logic       start;
    logic       collided;
    logic       missed_one;
    logic       missed_two;
    logic       restart;
    logic       play_en;
    logic       serve_dir;
    logic [3:0] score_one;
    logic [3:0] score_two;
    logic       game_over;
    logic       winner;
    logic [1:0] speed_level;

    int errors = 0;
    int checks = 0;

`ifdef PONG_RALLY_SPEEDUP_EN
    localparam logic [1:0] LVL_8  = 2'd2;
    localparam logic [1:0] LVL_13 = 2'd3;
`else
    localparam logic [1:0] LVL_8  = 2'd0;
    localparam logic [1:0] LVL_13 = 2'd0;
`endif

    typedef struct {
        string       name;
        logic [14:0] exp;
    } sb_t;

    typedef struct {
        string       name;
        bit          st;
        bit          col;
        bit          m1;
        bit          m2;
        int          frames;
        logic [14:0] exp;
    } vec_t;

    sb_t  sb_q[$];
    vec_t vecs[$];

    pong_match_controller dut (
        .clk50M      (clk50M),
        .reset       (reset),
        .endofframe  (endofframe),
        .start       (start),
        .collided    (collided),
        .missed_one  (missed_one),
        .missed_two  (missed_two),
        .restart     (restart),
        .play_en     (play_en),
        .serve_dir   (serve_dir),
        .score_one   (score_one),
        .score_two   (score_two),
        .game_over   (game_over),
        .winner      (winner),
        .speed_level (speed_level)
    );

    always #5 clk50M = ~clk50M;

    function automatic logic [14:0] mk(input bit rs, input bit pe, input bit sd,
                                       input int s1, input int s2, input bit go,
                                       input bit wn, input logic [1:0] spd);
        logic [3:0] a;
        logic [3:0] b;
        a = 4'(s1);
        b = 4'(s2);
        return {rs, pe, sd, a, b, go, wn, spd};
    endfunction

    // Each frame: inputs held stable, endofframe high 5 cycles then low 5 cycles.
    task automatic run_frames(input int n, input bit st, input bit col, input bit m1, input bit m2);
        for (int i = 0; i < n; i++) begin
            start      = st;
            collided   = col;
            missed_one = m1;
            missed_two = m2;
            endofframe = 1'b1;
            repeat (5) @(negedge clk50M);
            endofframe = 1'b0;
            repeat (5) @(negedge clk50M);
        end
    endtask

    task automatic expect_push(input string name, input logic [14:0] exp);
        sb_t e;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic compare_pop();
        sb_t         e;
        logic [14:0] got;
        e   = sb_q.pop_front();
        got = {restart, play_en, serve_dir, score_one, score_two, game_over, winner, speed_level};
        checks++;
        if (got !== e.exp) begin
            errors++;
            $display("FAIL %s: got rs/pe/sd=%b%b%b s1=%0d s2=%0d go/win=%b%b spd=%0d, expected rs/pe/sd=%b%b%b s1=%0d s2=%0d go/win=%b%b spd=%0d",
                     e.name, got[14], got[13], got[12], got[11:8], got[7:4], got[3], got[2], got[1:0],
                     e.exp[14], e.exp[13], e.exp[12], e.exp[11:8], e.exp[7:4], e.exp[3], e.exp[2], e.exp[1:0]);
        end
    endtask

    task automatic step(input string name, input int n, input bit st, input bit col,
                        input bit m1, input bit m2, input logic [14:0] exp);
        expect_push(name, exp);
        run_frames(n, st, col, m1, m2);
        compare_pop();
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        endofframe = 1'b0;
        start      = 1'b0;
        collided   = 1'b0;
        missed_one = 1'b0;
        missed_two = 1'b0;
        repeat (3) @(negedge clk50M);
        reset = 1'b0;
        repeat (2) @(negedge clk50M);
    endtask

    function automatic vec_t v(input string name, input bit st, input bit col, input bit m1,
                               input bit m2, input int frames, input logic [14:0] exp);
        vec_t r;
        r.name = name; r.st = st; r.col = col; r.m1 = m1; r.m2 = m2;
        r.frames = frames; r.exp = exp;
        return r;
    endfunction

    initial begin
        vecs.push_back(v("idle",         0, 0, 0, 0,  3, mk(1, 0, 0, 0, 0, 0, 0, 2'd0)));
        vecs.push_back(v("start",        1, 0, 0, 0,  1, mk(1, 0, 0, 0, 0, 0, 0, 2'd0)));
        vecs.push_back(v("serve_59",     0, 0, 0, 0, 59, mk(1, 0, 0, 0, 0, 0, 0, 2'd0)));
        vecs.push_back(v("serve_60",     0, 0, 0, 0,  1, mk(0, 1, 0, 0, 0, 0, 0, 2'd0)));
        vecs.push_back(v("miss_one",     0, 0, 1, 0,  1, mk(0, 0, 0, 0, 1, 0, 0, 2'd0)));
        vecs.push_back(v("point_29",     0, 0, 0, 0, 29, mk(0, 0, 0, 0, 1, 0, 0, 2'd0)));
        vecs.push_back(v("point_30",     0, 0, 0, 0,  1, mk(1, 0, 0, 0, 1, 0, 0, 2'd0)));
        vecs.push_back(v("serve_ignore", 0, 0, 1, 0,  1, mk(1, 0, 0, 0, 1, 0, 0, 2'd0)));
        vecs.push_back(v("serve_rest",   0, 0, 0, 0, 59, mk(0, 1, 0, 0, 1, 0, 0, 2'd0)));
        vecs.push_back(v("miss_two_col", 0, 1, 0, 1,  1, mk(0, 0, 1, 1, 1, 0, 0, 2'd0)));
        vecs.push_back(v("point_a",      0, 0, 0, 0, 30, mk(1, 0, 1, 1, 1, 0, 0, 2'd0)));
        vecs.push_back(v("serve_a",      0, 0, 0, 0, 60, mk(0, 1, 1, 1, 1, 0, 0, 2'd0)));
        vecs.push_back(v("double_miss",  0, 0, 1, 1,  1, mk(0, 0, 1, 1, 1, 0, 0, 2'd0)));
        vecs.push_back(v("point_b",      0, 0, 0, 0, 30, mk(1, 0, 1, 1, 1, 0, 0, 2'd0)));
        vecs.push_back(v("serve_b",      0, 0, 0, 0, 60, mk(0, 1, 1, 1, 1, 0, 0, 2'd0)));
        vecs.push_back(v("start_in_play",1, 0, 0, 0,  1, mk(0, 1, 1, 1, 1, 0, 0, 2'd0)));

        do_reset();
        expect_push("reset_state", mk(1, 0, 0, 0, 0, 0, 0, 2'd0));
        compare_pop();

        foreach (vecs[i]) begin
            step(vecs[i].name, vecs[i].frames, vecs[i].st, vecs[i].col,
                 vecs[i].m1, vecs[i].m2, vecs[i].exp);
        end

        // Reset mid-play at 3-2.
        do_reset();
        run_frames(1, 1, 0, 0, 0);
        run_frames(60, 0, 0, 0, 0);
        for (int p = 0; p < 5; p++) begin
            run_frames(1, 0, 0, (p >= 3), (p < 3));
            run_frames(90, 0, 0, 0, 0);
        end
        expect_push("play_3_2", mk(0, 1, 0, 3, 2, 0, 0, 2'd0));
        compare_pop();
        #2 reset = 1'b1;
        #1;
        expect_push("async_reset", mk(1, 0, 0, 0, 0, 0, 0, 2'd0));
        compare_pop();
        @(negedge clk50M);
        reset = 1'b0;
        repeat (2) @(negedge clk50M);

        // Win at 11-0, then re-arm only after release and new press.
        run_frames(1, 1, 0, 0, 0);
        run_frames(60, 0, 0, 0, 0);
        for (int p = 0; p < 10; p++) begin
            run_frames(1, 0, 0, 0, 1);
            run_frames(90, 0, 0, 0, 0);
        end
        expect_push("play_10_0", mk(0, 1, 1, 10, 0, 0, 0, 2'd0));
        compare_pop();
        step("win_one",      1, 1, 0, 0, 1, mk(1, 0, 1, 11, 0, 1, 0, 2'd0));
        step("start_held",   5, 1, 0, 0, 0, mk(1, 0, 1, 11, 0, 1, 0, 2'd0));
        step("start_release",1, 0, 0, 0, 0, mk(1, 0, 1, 11, 0, 1, 0, 2'd0));
        step("rearm",        1, 1, 0, 0, 0, mk(1, 0, 1, 0, 0, 0, 0, 2'd0));
        step("rearm_play",  60, 0, 0, 0, 0, mk(0, 1, 1, 0, 0, 0, 0, 2'd0));

        // Rally speed-up: 8 hits, then 13, then cleared on the next serve.
        for (int h = 0; h < 8; h++) begin
            run_frames(1, 0, 1, 0, 0);
            run_frames(1, 0, 0, 0, 0);
        end
        expect_push("hits_8", mk(0, 1, 1, 0, 0, 0, 0, LVL_8));
        compare_pop();
        for (int h = 0; h < 5; h++) begin
            run_frames(1, 0, 1, 0, 0);
            run_frames(1, 0, 0, 0, 0);
        end
        expect_push("hits_13", mk(0, 1, 1, 0, 0, 0, 0, LVL_13));
        compare_pop();
        step("miss_keeps_lvl", 1, 0, 0, 1, 0, mk(0, 0, 0, 0, 1, 0, 0, LVL_13));
        step("serve_clears",  30, 0, 0, 0, 0, mk(1, 0, 0, 0, 1, 0, 0, 2'd0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
